// File: rtl/mux_bus256_16to1_reader.sv
// Snapshots one of sixteen 256-bit banks on start and streams it out as eight
// 32-bit words, least-significant first, over a valid/ready interface.
module mux_bus256_16to1_reader (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   sel,
  input  logic         abort,
  input  logic [255:0] in_00,
  input  logic [255:0] in_01,
  input  logic [255:0] in_02,
  input  logic [255:0] in_03,
  input  logic [255:0] in_04,
  input  logic [255:0] in_05,
  input  logic [255:0] in_06,
  input  logic [255:0] in_07,
  input  logic [255:0] in_08,
  input  logic [255:0] in_09,
  input  logic [255:0] in_10,
  input  logic [255:0] in_11,
  input  logic [255:0] in_12,
  input  logic [255:0] in_13,
  input  logic [255:0] in_14,
  input  logic [255:0] in_15,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_idx,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         dbg_state
);

  // Handshake: a word transfers on a rising edge where out_valid and out_ready
  // are both high; once raised, out_valid and the word hold until a transfer,
  // abort or reset.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [255:0] shadow_q, shadow_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [31:0]  out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [2:0]   out_idx_q, out_idx_d;
  logic         out_last_q, out_last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [255:0] banks [16];

  assign banks[0]  = in_00;
  assign banks[1]  = in_01;
  assign banks[2]  = in_02;
  assign banks[3]  = in_03;
  assign banks[4]  = in_04;
  assign banks[5]  = in_05;
  assign banks[6]  = in_06;
  assign banks[7]  = in_07;
  assign banks[8]  = in_08;
  assign banks[9]  = in_09;
  assign banks[10] = in_10;
  assign banks[11] = in_11;
  assign banks[12] = in_12;
  assign banks[13] = in_13;
  assign banks[14] = in_14;
  assign banks[15] = in_15;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = banks[sel];
          cnt_d    = 3'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        // abort outranks a transfer landing on the same edge
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (out_ready) begin
          if (cnt_q == 3'd7) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so every port comes from a flop.
  always_comb begin
    out_data_d  = 32'd0;
    out_valid_d = 1'b0;
    out_idx_d   = 3'd0;
    out_last_d  = 1'b0;
    busy_d      = 1'b0;
    if (state_d == SEND) begin
      out_data_d  = shadow_d[{cnt_d, 5'd0} +: 32];
      out_valid_d = 1'b1;
      out_idx_d   = cnt_d;
      out_last_d  = (cnt_d == 3'd7);
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= 256'd0;
      cnt_q       <= 3'd0;
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 3'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_bus256_16to1_reader.sv
// Directed bench for mux_bus256_16to1_reader: full rate, backpressure,
// snapshot isolation, abort, async reset and back-to-back read-outs.
module tb_mux_bus256_16to1_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   sel;
  logic         abort;
  logic [255:0] in_arr [16];
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_bus256_16to1_reader dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .abort(abort),
    .in_00(in_arr[0]),  .in_01(in_arr[1]),  .in_02(in_arr[2]),  .in_03(in_arr[3]),
    .in_04(in_arr[4]),  .in_05(in_arr[5]),  .in_06(in_arr[6]),  .in_07(in_arr[7]),
    .in_08(in_arr[8]),  .in_09(in_arr[9]),  .in_10(in_arr[10]), .in_11(in_arr[11]),
    .in_12(in_arr[12]), .in_13(in_arr[13]), .in_14(in_arr[14]), .in_15(in_arr[15]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Bank 5 holds k*0x11111111 in word k; other banks carry a tag plus bank and word.
  function automatic logic [31:0] exp_word(input int b, input int j);
    logic [3:0] bb;
    logic [2:0] jj;
    bb = b[3:0];
    jj = j[2:0];
    if (b == 5) return j * 32'h11111111;
    return {4'hA, bb, 20'h5A5A5, 1'b0, jj};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input int b, input int j);
    logic [2:0] jj;
    jj = j[2:0];
    check({tag, " valid"}, out_valid, 1'b1);
    check({tag, " data"}, out_data, exp_word(b, j));
    check({tag, " idx"}, out_idx, jj);
    check({tag, " last"}, out_last, (j == 7));
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " done"}, done, 1'b0);
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    check({tag, " valid"}, out_valid, 1'b0);
    check({tag, " data"}, out_data, 32'd0);
    check({tag, " idx"}, out_idx, 3'd0);
    check({tag, " last"}, out_last, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, exp_done);
  endtask

  task automatic do_start(input logic [3:0] s);
    start = 1'b1;
    sel   = s;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 4'd0; abort = 1'b0; out_ready = 1'b0;
    for (int b = 0; b < 16; b++)
      for (int j = 0; j < 8; j++)
        in_arr[b][j*32 +: 32] = exp_word(b, j);
    tick(); tick();
    check_quiet("reset", 1'b0);
    rst = 1'b0;

    // idle with no start
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle valid", out_valid, 1'b0);
      check("idle busy", busy, 1'b0);
      check("idle done", done, 1'b0);
    end

    // full-rate read of bank 5
    out_ready = 1'b1;
    do_start(4'd5);
    for (int j = 0; j < 8; j++) begin
      check_word("full", 5, j);
      tick();
    end
    check_quiet("full end", 1'b1);
    tick();
    check_quiet("full after", 1'b0);

    // ready low on alternate cycles: 16 send cycles, done at N+17
    do_start(4'd5);
    for (int c = 0; c < 16; c++) begin
      check_word("bp", 5, c / 2);
      out_ready = (c % 2 == 1);
      tick();
    end
    check_quiet("bp end", 1'b1);
    out_ready = 1'b1;
    tick();

    // bank change and start while sending must not disturb the read-out
    do_start(4'd5);
    for (int j = 0; j < 8; j++) begin
      check_word("snap", 5, j);
      if (j == 3) begin
        in_arr[5] = '1;
        start = 1'b1;
        sel = 4'd2;
      end
      tick();
      start = 1'b0;
    end
    check_quiet("snap end", 1'b1);
    tick();
    check_quiet("snap no restart", 1'b0);
    for (int j = 0; j < 8; j++) in_arr[5][j*32 +: 32] = exp_word(5, j);

    // abort on word 3 with ready high
    do_start(4'd5);
    for (int j = 0; j < 4; j++) begin
      check_word("abort pre", 5, j);
      if (j == 3) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check_quiet("abort", 1'b0);
    check("abort state", dbg_state, 1'b0);
    tick();
    check_quiet("abort after", 1'b0);
    do_start(4'd15);
    for (int j = 0; j < 8; j++) begin
      check_word("bank15", 15, j);
      tick();
    end
    check_quiet("bank15 end", 1'b1);
    tick();

    // asynchronous reset during word 4
    do_start(4'd7);
    for (int j = 0; j < 5; j++) begin
      check_word("rstmid", 7, j);
      if (j < 4) tick();
    end
    #1 rst = 1'b1;
    #1 check_quiet("rst async", 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_quiet("rst after", 1'b0);

    // back-to-back: start bank 1 in the done cycle of bank 0
    do_start(4'd0);
    for (int j = 0; j < 8; j++) begin
      check_word("b2b0", 0, j);
      tick();
    end
    check_quiet("b2b0 done", 1'b1);
    do_start(4'd1);
    for (int j = 0; j < 8; j++) begin
      check_word("b2b1", 1, j);
      tick();
    end
    check_quiet("b2b1 done", 1'b1);
    tick();
    check_quiet("final idle", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_bus256_16to1_reader.md
# mux_bus256_16to1_reader

Read-back counterpart of the 1-to-16 256-bit bus demux in the Top CDT design. On a start request it selects one of sixteen 256-bit banks, snapshots it, and returns it as eight 32-bit words, least-significant first, over a valid/ready stream. It sits between the bank registers and the 32-bit register/readout interface that originally loaded them as reg0..reg7.

## Interface

- Parameters: none; all widths are fixed.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a read-out of bank `sel`; sampled only in IDLE
- sel  in  4  bank index 0..15, sampled with `start`
- abort  in  1  synchronous cancel of a read-out in progress
- in_00 .. in_15  in  256 each  bank contents; bits [32k+31:32k] are word k
- out_data  out  32  current word
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream accepts the word
- out_idx  out  3  index 0..7 of the word on out_data
- out_last  out  1  high with word 7
- busy  out  1  read-out in progress, state SEND
- done  out  1  one-cycle pulse after word 7 is accepted

## Operation

- States: IDLE and SEND.
- IDLE, start=1:
  - Capture in_<sel> into a 256-bit shadow register.
  - Set the word counter to 0 and go to SEND.
  - Later changes to in_xx or sel have no effect on this read-out.
- IDLE, start=0: hold; out_valid=0.
- SEND:
  - out_valid=1.
  - out_data = shadow[32·cnt+31 : 32·cnt].
  - out_idx = cnt.
  - out_last = (cnt==7).
  - busy=1.
- Transfer occurs on a rising edge where out_valid=1 and out_ready=1.
  - cnt<7: cnt increments.
  - cnt==7: go to IDLE and pulse done=1 for exactly the next cycle.
- Stall: with out_ready=0, out_data, out_idx and out_last hold stable and out_valid stays high. out_valid never drops without a transfer, except on abort or rst.
- start in SEND is ignored; it is not queued.
- abort in SEND:
  - Go to IDLE on that edge. No done pulse.
  - out_valid drops the next cycle, even if a transfer coincides on that edge.
  - abort has priority over the transfer.
- abort in IDLE: no effect. abort and start together in IDLE: start wins and abort is ignored.
- start is accepted in the cycle done is high, because the state is IDLE; back-to-back read-outs are allowed.
- Reset values (asynchronous, including mid-read-out, with no done):
  - state=IDLE, shadow=0, cnt=0
  - out_data=0, out_valid=0, out_idx=0, out_last=0
  - busy=0, done=0
- In IDLE, out_data, out_idx and out_last are driven to 0.

## Timing

- start sampled at edge N gives out_valid=1 with word 0 in cycle N+1 (1-cycle latency).
- With out_ready held high, words 0..7 appear in cycles N+1..N+8, one per cycle. done=1 and busy=0 in cycle N+9.
- Each out_ready low cycle during SEND adds exactly one cycle.
- out_data, out_valid, out_idx, out_last, busy and done are all registered; there is no combinational path from out_ready to any output.
- Minimum period between accepted starts is 9 cycles.

## Test plan

- Reset then idle: rst pulse mid-cycle → all outputs 0 asynchronously; with start=0 for 20 cycles → out_valid, busy and done stay 0.
- Full-rate read, bank 5: in_05 = {32'h77777777, …, 32'h11111111, 32'h00000000} (word k = k·32'h11111111), start with sel=5, out_ready=1 → words 0x00000000..0x77777777 with out_idx 0..7 in cycles N+1..N+8; out_last only on 0x77777777; done in N+9.
- Backpressure: same bank with out_ready low on alternate cycles → each word held stable while stalled; 8 transfers; done at N+17; no word duplicated or skipped.
- Snapshot isolation and ignored start: change in_05 to all 1s and pulse start with sel=2 after word 2 → remaining words still come from the original in_05; no second read-out starts.
- Abort: abort asserted in the cycle showing word 3 with out_ready=1 → IDLE, out_valid=0 next cycle, no done; a new start with sel=15 then streams in_15 words 0..7 from index 0.
- Reset mid-operation and back-to-back: rst during word 4 → outputs 0 and no done; then start at the done cycle of a completed bank-0 read → bank-1 word 0 appears the following cycle.
